register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
// - RV32I integer register file. It is the consumer end of the write-back path: write_back_unit drives
//   write_data, and this block commits it to rd.
// - Provides two asynchronous read ports (rs1/rs2) to decode/execute.
// - Tracks one busy bit per register. A register is busy from issue until its write-back commits, so
//   decode can stall on RAW hazards.
// PARAMETERS
// - XLEN      32  data width in bits
// - REG_NUM   32  number of architectural registers; x0 is hardwired to zero
// - ADDR_W     5  register index width; must equal clog2(REG_NUM)
// PORTS
// - clk            in   1      rising-edge clock
// - rst_n          in   1      asynchronous active-low reset
// - rs1_addr       in   ADDR_W source register 1 index
// - rs2_addr       in   ADDR_W source register 2 index
// - rs1_data       out  XLEN   contents of rs1 (combinational)
// - rs2_data       out  XLEN   contents of rs2 (combinational)
// - rs1_busy       out  1      rs1 has an outstanding write (combinational)
// - rs2_busy       out  1      rs2 has an outstanding write (combinational)
// - issue_valid    in   1      an instruction that writes rd is issued this cycle
// - issue_rd       in   ADDR_W destination index of the issuing instruction
// - wb_en          in   1      write-back commit strobe
// - wb_rd          in   ADDR_W write-back destination index
// - wb_data        in   XLEN   write_data taken from write_back_unit
// - busy_any       out  1      OR of all busy bits; used for fence/drain
// BEHAVIOUR
// - Reset (rst_n low, asynchronous): all registers are 0, all busy bits are 0, busy_any is 0.
//   Read outputs reflect these cleared values. Reset asserted mid-operation discards pending busy bits.
// - Write: on posedge clk with wb_en=1 and wb_rd!=0, reg[wb_rd] <= wb_data.
//   - The new value is visible on rs*_data the cycle after the edge.
// - x0: reads always return 0 and busy is always 0. Writes and issues to x0 are ignored.
// - Reads: rs*_data = reg[rs*_addr] and rs*_busy = busy[rs*_addr]. Purely combinational, zero latency.
// - Scoreboard, evaluated on posedge clk:
//   - issue_valid && issue_rd!=0 sets busy[issue_rd].
//   - wb_en && wb_rd!=0 clears busy[wb_rd].
//   - Both events on the same index in the same cycle: the set wins, and busy stays 1. That issue is a
//     newer writer that overwrites the older one.
//   - Both events on different indices: both take effect.
// - Write-back to a register that is not busy: the data is still written and the busy bit stays 0. This
//   case is legal, for example for the first write after reset.
// - Both read ports may address the same register; each output is independent.
// CONFIGURATION
// - REGFILE_BYPASS_EN defined: a read in the same cycle as a commit to the same index returns wb_data.
//   - When rs*_addr==wb_rd, wb_en=1 and wb_rd!=0, then rs*_data = wb_data and rs*_busy = 0. The
//     pipeline sees the value in the cycle of the write.
//   - When a same-cycle issue to the same index sets busy[rs*], rs*_busy still reads 0 in that cycle.
//     The set becomes visible the next cycle.
// - REGFILE_BYPASS_EN undefined: no bypass. Reads return the stored value and stored busy bit. Decode
//   must stall one extra cycle.
// STRUCTURE
// - Shared include inc/registers_writeback.v carries:
//   - existing REG_WB_* selects
//   - new `REG_ADDR_W (5), `REG_XLEN (32), `REG_ZERO (5'd0)
// - Sub-module register_scoreboard holds the REG_NUM busy bits and the set/clear priority logic.
//   - Ports: clk, rst_n, set_en, set_idx, clr_en, clr_idx, rd_idx_a, rd_idx_b, busy_a, busy_b, busy_any.
// - The top level holds the storage array, x0 masking and the optional bypass muxes.
// TESTING
// - Reset: drive rst_n=0 asynchronously mid-cycle.
//   - rs1_data=0 for every rs1_addr 0..31; busy_any=0 immediately, without waiting for a clock edge.
// - Write/read:
//   - wb_en=1, wb_rd=5, wb_data=32'hA5A5A5A5, then rs1_addr=5 -> rs1_data=A5A5A5A5 next cycle.
//   - Same data with wb_rd=0 -> rs2_addr=0 gives 0.
// - Scoreboard:
//   - issue_valid=1, issue_rd=7 -> rs1_busy=1 for rs1_addr=7 next cycle; busy_any=1.
//   - wb_en with wb_rd=7 -> busy clears and busy_any=0.
// - Same cycle, same index: busy[9]=1, then issue_rd=9 and wb_rd=9 in one cycle -> busy[9] stays 1 and
//   reg[9] updated.
// - Bypass:
//   - With REGFILE_BYPASS_EN, wb_rd=3, wb_data=32'h12345678, rs1_addr=3 -> rs1_data=12345678 in the
//     same cycle.
//   - Without the macro, the old value appears in that cycle and 12345678 in the next.
// - Dual read: rs1_addr=rs2_addr=5 -> both ports return the same value. Then rs1_addr=5, rs2_addr=6 ->
//   each port returns its own register, with no cross-talk.

Source files
------------

// File: rtl/register_file_pkg.sv
// ---------------------------------------------------------------------------
// register_file_pkg
// Shared constants for the RV32I integer register file and its busy-bit
// scoreboard.
//   REG_XLEN   : data width of one architectural register
//   REG_NUM    : number of architectural registers (x0 is hardwired to zero)
//   REG_ADDR_W : register index width, equals clog2(REG_NUM)
//   REG_ZERO   : index of the hardwired-zero register x0
// ---------------------------------------------------------------------------
package register_file_pkg;

  localparam int REG_XLEN   = 32;
  localparam int REG_NUM    = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage : register_file_pkg

// File: rtl/register_scoreboard.sv
// ---------------------------------------------------------------------------
// register_scoreboard
// One busy bit per architectural register. A bit is set when an instruction
// that writes the register issues and cleared when its write-back commits.
// Bit 0 (x0) is never set.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   set_en, set_idx     issue event: mark set_idx busy
//   clr_en, clr_idx     commit event: clear busy on clr_idx
//   rd_idx_a/b          lookup indices
//   busy_a/b            stored busy bits for rd_idx_a/b (combinational)
//   busy_any            OR of all busy bits
// ---------------------------------------------------------------------------
module register_scoreboard
  import register_file_pkg::*;
#(
  parameter int REG_NUM = register_file_pkg::REG_NUM,
  parameter int ADDR_W  = register_file_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_idx,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_idx,
  input  logic [ADDR_W-1:0] rd_idx_a,
  input  logic [ADDR_W-1:0] rd_idx_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic              busy_any
);

  logic [REG_NUM-1:0] r_busy;
  logic [REG_NUM-1:0] w_busy_nxt;

  // Next busy vector: a set beats a clear on the same index, because the
  // issuing instruction is a newer writer than the one committing.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 1; i < REG_NUM; i++) begin
      if (set_en && (set_idx == ADDR_W'(i))) begin
        w_busy_nxt[i] = 1'b1;
      end else if (clr_en && (clr_idx == ADDR_W'(i))) begin
        w_busy_nxt[i] = 1'b0;
      end else begin
        w_busy_nxt[i] = r_busy[i];
      end
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Busy-bit state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign busy_a   = r_busy[rd_idx_a];
  assign busy_b   = r_busy[rd_idx_b];
  assign busy_any = |r_busy;

endmodule : register_scoreboard

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
// RV32I integer register file: storage array, two combinational read ports,
// write-back commit port and a per-register busy scoreboard for RAW stalls.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rs1_addr/rs2_addr          read indices
//   rs1_data/rs2_data          read data (combinational, x0 reads 0)
//   rs1_busy/rs2_busy          outstanding-write flags (combinational)
//   issue_valid, issue_rd      issue of an instruction writing issue_rd
//   wb_en, wb_rd, wb_data      write-back commit from write_back_unit
//   busy_any                   any register has an outstanding write
// Configuration macro:
//   REGFILE_BYPASS_EN  when defined, a read of the index being committed in
//                      the same cycle returns wb_data and reports not busy.
// ---------------------------------------------------------------------------
module register_file
  import register_file_pkg::*;
#(
  parameter int XLEN    = REG_XLEN,
  parameter int REG_NUM = register_file_pkg::REG_NUM,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              busy_any
);

  logic [XLEN-1:0] r_regs [REG_NUM];
  logic            w_wb_commit;
  logic            w_busy1;
  logic            w_busy2;

  // Writes to x0 are discarded here as well as in the scoreboard.
  assign w_wb_commit = wb_en && (wb_rd != '0);

  register_scoreboard #(
    .REG_NUM (REG_NUM),
    .ADDR_W  (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (issue_valid),
    .set_idx  (issue_rd),
    .clr_en   (wb_en),
    .clr_idx  (wb_rd),
    .rd_idx_a (rs1_addr),
    .rd_idx_b (rs2_addr),
    .busy_a   (w_busy1),
    .busy_b   (w_busy2),
    .busy_any (busy_any)
  );

  // Storage array; entry 0 is cleared on reset and never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_commit) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  // Read port 1: x0 masking plus optional same-cycle commit bypass.
  always_comb begin
    rs1_data = '0;
    rs1_busy = 1'b0;
    if (rs1_addr == '0) begin
      rs1_data = '0;
      rs1_busy = 1'b0;
`ifdef REGFILE_BYPASS_EN
    end else if (w_wb_commit && (rs1_addr == wb_rd)) begin
      rs1_data = wb_data;
      rs1_busy = 1'b0;
`endif
    end else begin
      rs1_data = r_regs[rs1_addr];
      rs1_busy = w_busy1;
    end
  end

  // Read port 2: same structure as port 1, fully independent.
  always_comb begin
    rs2_data = '0;
    rs2_busy = 1'b0;
    if (rs2_addr == '0) begin
      rs2_data = '0;
      rs2_busy = 1'b0;
`ifdef REGFILE_BYPASS_EN
    end else if (w_wb_commit && (rs2_addr == wb_rd)) begin
      rs2_data = wb_data;
      rs2_busy = 1'b0;
`endif
    end else begin
      rs2_data = r_regs[rs2_addr];
      rs2_busy = w_busy2;
    end
  end

endmodule : register_file

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
// Directed stimulus drives register_file; each step pushes its hand-computed
// expectations into a queue, and a monitor on the falling clock edge pops
// and compares them against the live outputs.
// ---------------------------------------------------------------------------
module tb_register_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy_any;

  localparam int K_RS1D = 0;
  localparam int K_RS2D = 1;
  localparam int K_RS1B = 2;
  localparam int K_RS2B = 3;
  localparam int K_BANY = 4;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t        q[$];
  int          n_cmp;
  int          n_bad;
  exp_t        m_e;
  logic [31:0] m_act;

  register_file dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .busy_any    (busy_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string kname(input int k);
    case (k)
      K_RS1D:  return "rs1_data";
      K_RS2D:  return "rs2_data";
      K_RS1B:  return "rs1_busy";
      K_RS2B:  return "rs2_busy";
      K_BANY:  return "busy_any";
      default: return "unknown";
    endcase
  endfunction

  task automatic exp_push(input int kind, input logic [31:0] v);
    exp_t e;
    e.kind = kind;
    e.val  = v;
    q.push_back(e);
  endtask

  // Let the monitor sample at the falling edge, then move to just after the
  // next rising edge where the following step's inputs are applied.
  task automatic cyc();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every queued expectation against the current outputs.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      m_e = q.pop_front();
      case (m_e.kind)
        K_RS1D:  m_act = rs1_data;
        K_RS2D:  m_act = rs2_data;
        K_RS1B:  m_act = {31'd0, rs1_busy};
        K_RS2B:  m_act = {31'd0, rs2_busy};
        K_BANY:  m_act = {31'd0, busy_any};
        default: m_act = 32'hxxxx_xxxx;
      endcase
      n_cmp = n_cmp + 1;
      if (m_act !== m_e.val) begin
        n_bad = n_bad + 1;
        $display("FAIL %s: got %h, want %h (t=%0t)", kname(m_e.kind), m_act, m_e.val, $time);
      end
    end
  end

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    rst_n       = 1'b0;
    rs1_addr    = 5'd0;
    rs2_addr    = 5'd0;
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
    wb_en       = 1'b0;
    wb_rd       = 5'd0;
    wb_data     = 32'd0;

    // Reset: every register reads zero, nothing busy.
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a);
      exp_push(K_RS1D, 32'd0);
      exp_push(K_BANY, 32'd0);
      cyc();
    end
    rst_n = 1'b1;

    // Write x5 (not busy: data written, busy stays 0).
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hA5A5_A5A5; rs1_addr = 5'd5;
    exp_push(K_RS1D, BYP ? 32'hA5A5_A5A5 : 32'd0);
    cyc();
    wb_en = 1'b0;
    exp_push(K_RS1D, 32'hA5A5_A5A5);
    exp_push(K_RS1B, 32'd0);
    cyc();

    // Write to x0 is ignored, also by the bypass.
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hA5A5_A5A5; rs2_addr = 5'd0;
    exp_push(K_RS2D, 32'd0);
    cyc();
    wb_en = 1'b0;
    exp_push(K_RS2D, 32'd0);
    exp_push(K_RS2B, 32'd0);
    cyc();

    // Issue x7: busy visible the cycle after.
    issue_valid = 1'b1; issue_rd = 5'd7; rs1_addr = 5'd7;
    exp_push(K_RS1B, 32'd0);
    exp_push(K_BANY, 32'd0);
    cyc();
    issue_valid = 1'b0;
    exp_push(K_RS1B, 32'd1);
    exp_push(K_BANY, 32'd1);
    cyc();

    // Commit x7: busy clears.
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h0000_7777;
    exp_push(K_RS1B, BYP ? 32'd0 : 32'd1);
    exp_push(K_RS1D, BYP ? 32'h0000_7777 : 32'd0);
    cyc();
    wb_en = 1'b0;
    exp_push(K_RS1B, 32'd0);
    exp_push(K_BANY, 32'd0);
    exp_push(K_RS1D, 32'h0000_7777);
    cyc();

    // x9 busy, then issue and commit x9 in one cycle: set wins, data written.
    issue_valid = 1'b1; issue_rd = 5'd9; rs2_addr = 5'd9;
    cyc();
    wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'h9999_0009;
    exp_push(K_RS2B, BYP ? 32'd0 : 32'd1);
    cyc();
    issue_valid = 1'b0; wb_en = 1'b0;
    exp_push(K_RS2B, 32'd1);
    exp_push(K_RS2D, 32'h9999_0009);
    exp_push(K_BANY, 32'd1);
    cyc();
    wb_en = 1'b1;
    cyc();
    wb_en = 1'b0;
    exp_push(K_RS2B, 32'd0);
    exp_push(K_BANY, 32'd0);
    cyc();

    // Issue to x0 is ignored.
    issue_valid = 1'b1; issue_rd = 5'd0; rs1_addr = 5'd0;
    cyc();
    issue_valid = 1'b0;
    exp_push(K_RS1B, 32'd0);
    exp_push(K_BANY, 32'd0);
    cyc();

    // Issue x10 and commit x11 in the same cycle: both take effect.
    issue_valid = 1'b1; issue_rd = 5'd10;
    wb_en = 1'b1; wb_rd = 5'd11; wb_data = 32'h0B0B_0B0B;
    cyc();
    issue_valid = 1'b0; wb_en = 1'b0;
    rs1_addr = 5'd10; rs2_addr = 5'd11;
    exp_push(K_RS1B, 32'd1);
    exp_push(K_RS2B, 32'd0);
    exp_push(K_RS2D, 32'h0B0B_0B0B);
    cyc();
    wb_en = 1'b1; wb_rd = 5'd10; wb_data = 32'h0A0A_0A0A;
    cyc();
    wb_en = 1'b0;
    exp_push(K_RS1B, 32'd0);
    exp_push(K_RS1D, 32'h0A0A_0A0A);
    cyc();

    // Same-cycle read of a committing register.
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h1234_5678; rs1_addr = 5'd3;
    exp_push(K_RS1D, BYP ? 32'h1234_5678 : 32'd0);
    cyc();
    wb_en = 1'b0;
    exp_push(K_RS1D, 32'h1234_5678);
    cyc();

    // Dual read: same register on both ports, then distinct registers.
    wb_en = 1'b1; wb_rd = 5'd6; wb_data = 32'h6666_6666;
    cyc();
    wb_en = 1'b0;
    rs1_addr = 5'd5; rs2_addr = 5'd5;
    exp_push(K_RS1D, 32'hA5A5_A5A5);
    exp_push(K_RS2D, 32'hA5A5_A5A5);
    cyc();
    rs2_addr = 5'd6;
    exp_push(K_RS1D, 32'hA5A5_A5A5);
    exp_push(K_RS2D, 32'h6666_6666);
    cyc();

    // Mid-operation asynchronous reset discards pending busy bits.
    issue_valid = 1'b1; issue_rd = 5'd12;
    cyc();
    issue_valid = 1'b0;
    rs2_addr = 5'd12;
    exp_push(K_BANY, 32'd1);
    cyc();
    rst_n = 1'b0;
    exp_push(K_BANY, 32'd0);
    exp_push(K_RS2B, 32'd0);
    exp_push(K_RS1D, 32'd0);
    cyc();
    rst_n = 1'b1;
    exp_push(K_BANY, 32'd0);
    exp_push(K_RS2D, 32'd0);
    cyc();

    // Drain: bounded wait for the monitor to consume every expectation.
    for (int k = 0; k < 10 && q.size() > 0; k++) begin
      @(negedge clk);
    end
    #1;
    if (q.size() > 0) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_register_file
